// File: rtl/hls_kernel_run_ctrl.sv
// hls_kernel_run_ctrl: issues one kernel start per run request, times the run, checks the return value
module hls_kernel_run_ctrl #(
    parameter int          RET_W          = 32,
    parameter int          CYC_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_req,
    input  logic             check_en,
    input  logic [RET_W-1:0] exp_value,
    output logic             start_port,
    input  logic             done_port,
    input  logic [RET_W-1:0] return_port,
    output logic             busy,
    output logic             result_valid,
    output logic             result_pass,
    output logic             result_checked,
    output logic             result_timeout,
    output logic [RET_W-1:0] result_value,
    output logic [CYC_W-1:0] result_cycles,
    output logic [15:0]      run_count,
    output logic             spurious_done
);
    typedef enum logic [1:0] {IDLE, START, WAIT, REPORT} state_t;
    localparam logic [CYC_W-1:0] TMO = CYC_W'(TIMEOUT_CYCLES);
    state_t state, state_next;
    logic [RET_W-1:0] exp_q;
    logic chk_q;
    logic [CYC_W-1:0] cnt;
    logic done_hit, tmo_hit;
    always_comb begin
        done_hit = done_port && (state == START || state == WAIT);
        tmo_hit = state == WAIT && !done_port && cnt >= TMO;
        state_next = state;
        case (state)
            IDLE:    state_next = run_req ? START : IDLE;
            START:   state_next = done_port ? REPORT : WAIT;
            WAIT:    state_next = (done_port || tmo_hit) ? REPORT : WAIT;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end
    // cnt holds the cycle number of the current cycle, counting the start cycle as 1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_port <= 1'b0;
            busy <= 1'b0;
            result_valid <= 1'b0;
            result_pass <= 1'b0;
            result_checked <= 1'b0;
            result_timeout <= 1'b0;
            result_value <= '0;
            result_cycles <= '0;
            run_count <= '0;
            spurious_done <= 1'b0;
            exp_q <= '0;
            chk_q <= 1'b0;
            cnt <= '0;
        end else begin
            start_port <= state_next == START;
            busy <= state_next != IDLE;
            result_valid <= state_next == REPORT;
            spurious_done <= spurious_done | (done_port && (state == IDLE || state == REPORT));
            if (state == IDLE && run_req) begin
                exp_q <= exp_value;
                chk_q <= check_en;
            end
            if (state_next == START) cnt <= CYC_W'(1);
            else if ((state == START || state == WAIT) && cnt < TMO) cnt <= cnt + CYC_W'(1);
            if (done_hit || tmo_hit) begin
                result_value <= done_hit ? return_port : '0;
                result_timeout <= !done_hit;
                result_cycles <= cnt;
                result_checked <= chk_q;
                result_pass <= chk_q && done_hit && return_port == exp_q;
                run_count <= run_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_hls_kernel_run_ctrl.sv
// tb_hls_kernel_run_ctrl: directed and randomized runs checked against a run-level model
module tb_hls_kernel_run_ctrl;
    localparam int TMO = 16;
    logic clock = 1'b0, reset = 1'b0, run_req = 1'b0, check_en = 1'b0, done_port = 1'b0;
    logic [31:0] exp_value = '0, return_port = '0;
    logic start_port, busy, result_valid, result_pass, result_checked, result_timeout, spurious_done;
    logic [31:0] result_value, result_cycles;
    logic [15:0] run_count;
    int checks = 0, errors = 0, runs = 0;

    hls_kernel_run_ctrl #(.RET_W(32), .CYC_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .run_req(run_req), .check_en(check_en), .exp_value(exp_value),
        .start_port(start_port), .done_port(done_port), .return_port(return_port), .busy(busy),
        .result_valid(result_valid), .result_pass(result_pass), .result_checked(result_checked),
        .result_timeout(result_timeout), .result_value(result_value), .result_cycles(result_cycles),
        .run_count(run_count), .spurious_done(spurious_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // lat = cycles after the start cycle at which the kernel finishes
    task automatic run(input int lat, input logic [31:0] ret, input logic c, input logic [31:0] e, input bit hold);
        int cyc, ec;
        bit seen, to;
        to = lat >= TMO;
        ec = to ? TMO : lat + 1;
        run_req = 1'b1; check_en = c; exp_value = e;
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clock);
            seen = start_port;
        end
        chk("start_seen", 64'(seen), 1);
        chk("busy_start", busy, 1);
        if (!hold) begin
            run_req = 1'b0; check_en = ~c; exp_value = ~e;
        end
        cyc = 0; seen = 0;
        while (!seen && cyc < TMO + 8) begin
            done_port = !to && cyc == lat;
            return_port = done_port ? ret : 32'hdead_beef;
            @(negedge clock);
            cyc++;
            done_port = 1'b0;
            seen = result_valid;
            if (!seen) chk("start_low_wait", start_port, 0);
        end
        runs++;
        chk("rv_latency", 64'(cyc), 64'(ec));
        chk("busy_report", busy, 1);
        chk("pass", result_pass, 64'(c && !to && ret == e));
        chk("checked", result_checked, 64'(c));
        chk("timeout", result_timeout, 64'(to));
        chk("value", result_value, to ? 64'd0 : 64'(ret));
        chk("cycles", result_cycles, 64'(ec));
        chk("run_count", run_count, 64'(16'(runs)));
        if (!hold) begin
            @(negedge clock);
            chk("rv_pulse", result_valid, 0);
            chk("busy_idle", busy, 0);
            chk("cycles_hold", result_cycles, 64'(ec));
        end
    endtask

    initial begin
        logic [31:0] r;
        repeat (2) @(negedge clock);
        chk("rst_start", start_port, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_value", result_value, 0);
        chk("rst_count", run_count, 0);
        reset = 1'b1;
        @(negedge clock);
        run(5, 32'd42, 1'b1, 32'd42, 0);
        run(5, 32'd41, 1'b1, 32'd42, 0);
        run(TMO, 32'd5, 1'b1, 32'd5, 0);
        run(TMO - 1, 32'd9, 1'b1, 32'd9, 0);
        run(0, 32'd7, 1'b0, 32'd7, 0);
        chk("spur_before", spurious_done, 0);
        done_port = 1'b1;
        @(negedge clock);
        done_port = 1'b0;
        @(negedge clock);
        chk("spur_after", spurious_done, 1);
        chk("spur_count", run_count, 64'(16'(runs)));
        for (int i = 0; i < 3; i++) run(2, 32'd3, 1'b1, 32'd3, 1);
        run_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("b2b_idle", busy, 0);
        for (int i = 0; i < 10; i++) begin
            r = $urandom;
            run($urandom_range(0, TMO + 3), r, 1'($urandom_range(0, 1)), $urandom_range(0, 1) ? r : $urandom, 0);
        end
        run_req = 1'b1; check_en = 1'b1; exp_value = 32'd1;
        @(negedge clock);
        run_req = 1'b0;
        repeat (3) @(negedge clock);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        runs = 0;
        chk("arst_start", start_port, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rv", result_valid, 0);
        chk("arst_count", run_count, 0);
        chk("arst_spur", spurious_done, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run(3, 32'd99, 1'b1, 32'd99, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
